// File: rtl/numlock_code_player.sv
// numlock_code_player: plays a CODE_LEN-bit combination on the U/Z buttons,
// MSB first (1 = U press, 0 = Z press), each press followed by a release gap,
// then watches Unlock and reports pass/fail.
module numlock_code_player #(
  parameter int unsigned CODE_LEN  = 4,
  parameter int unsigned PRESS_CYC = 5,
  parameter int unsigned GAP_CYC   = 3,
  parameter int unsigned WAIT_CYC  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code,
  input  logic                Unlock,
  output logic                U,
  output logic                Z,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail
);

  localparam int unsigned MAX_PG  = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
  localparam int unsigned MAX_CYC = (MAX_PG > WAIT_CYC) ? MAX_PG : WAIT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LOAD   = IDX_W'(CODE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [CODE_LEN-1:0] code_r;
  logic [IDX_W-1:0]    idx_dec;

  assign idx_dec = idx - 1'b1;

  // Sequencer: counter counts down from (phase length - 1) and is reloaded
  // on every state entry; button outputs are set together with the state
  // change so they line up with the phase they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      code_r <= '0;
      U      <= 1'b0;
      Z      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
      fail   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            code_r <= code;
            idx    <= IDX_LOAD;
            cnt    <= PRESS_LOAD;
            pass   <= 1'b0;
            fail   <= 1'b0;
            busy   <= 1'b1;
            U      <= code[CODE_LEN-1];
            Z      <= ~code[CODE_LEN-1];
            state  <= S_PRESS;
          end
        end
        S_PRESS: begin
          if (Unlock) begin
            fail  <= 1'b1;
            done  <= 1'b1;
            U     <= 1'b0;
            Z     <= 1'b0;
            state <= S_DONE;
          end else if (cnt == '0) begin
            U     <= 1'b0;
            Z     <= 1'b0;
            cnt   <= GAP_LOAD;
            state <= S_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (Unlock) begin
            fail  <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (cnt == '0) begin
            if (idx != '0) begin
              idx   <= idx_dec;
              U     <= code_r[idx_dec];
              Z     <= ~code_r[idx_dec];
              cnt   <= PRESS_LOAD;
              state <= S_PRESS;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= S_WAIT;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (Unlock) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (cnt == '0) begin
            fail  <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          U     <= 1'b0;
          Z     <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_numlock_code_player.sv
// Directed bench for numlock_code_player with default parameters.
// Cycle n means the n-th clock period after the edge that accepted start.
module tb_numlock_code_player;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] code;
  logic       Unlock;
  logic       U, Z, busy, done, pass, fail;

  int unsigned total = 0;
  int unsigned bad   = 0;

  numlock_code_player #(
    .CODE_LEN (4),
    .PRESS_CYC(5),
    .GAP_CYC  (3),
    .WAIT_CYC (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .code  (code),
    .Unlock(Unlock),
    .U     (U),
    .Z     (Z),
    .busy  (busy),
    .done  (done),
    .pass  (pass),
    .fail  (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Check every output against expected values for the current cycle, then advance.
  task automatic expect_cycle(input string tag, input logic u, input logic z,
                              input logic b, input logic d, input logic p,
                              input logic f);
    chk({tag, ".U"}, U, u);
    chk({tag, ".Z"}, Z, z);
    chk({tag, ".UZ_excl"}, U & Z, 1'b0);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, done, d);
    chk({tag, ".pass"}, pass, p);
    chk({tag, ".fail"}, fail, f);
    tick();
  endtask

  // Expected press/gap pattern for the first npress bits of cv, starting in cycle 1.
  // If poke_at is nonzero, a start with code 0000 is pulsed at that cycle.
  task automatic run_presses(input logic [3:0] cv, input int unsigned npress,
                             input int unsigned poke_at);
    int unsigned cyc;
    logic        bitv;
    cyc = 1;
    for (int unsigned i = 0; i < npress; i++) begin
      bitv = cv[3-i];
      for (int unsigned c = 0; c < 8; c++) begin
        if (c < 5) begin
          chk("press.U", U, bitv);
          chk("press.Z", Z, ~bitv);
        end else begin
          chk("gap.U", U, 1'b0);
          chk("gap.Z", Z, 1'b0);
        end
        chk("seq.busy", busy, 1'b1);
        chk("seq.done", done, 1'b0);
        chk("seq.fail", fail, 1'b0);
        chk("seq.pass", pass, 1'b0);
        if (cyc == poke_at) begin
          start = 1'b1;
          code  = 4'b0000;
        end
        tick();
        start = 1'b0;
        cyc++;
      end
    end
  endtask

  task automatic do_start(input logic [3:0] cv);
    code  = cv;
    start = 1'b1;
    tick();
    start = 1'b0;
    code  = 4'b0101;  // later code changes must have no effect
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    code   = 4'b0000;
    Unlock = 1'b0;

    // Reset held for two cycles, with a concurrent start that must be ignored
    start = 1'b1;
    code  = 4'b1111;
    tick();
    expect_cycle("rst0", 0, 0, 0, 0, 0, 0);
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) expect_cycle("idle", 0, 0, 0, 0, 0, 0);

    // 1011 with Unlock tied low: timeout, done at cycle 49
    do_start(4'b1011);
    run_presses(4'b1011, 4, 0);
    for (int i = 0; i < 16; i++) expect_cycle("wait_to", 0, 0, 1, 0, 0, 0);
    expect_cycle("done_to", 0, 0, 1, 1, 0, 1);
    expect_cycle("after_to", 0, 0, 0, 0, 0, 1);
    expect_cycle("hold_to", 0, 0, 0, 0, 0, 1);

    // 1011 with Unlock two cycles after the final release: pass, done at cycle 35
    do_start(4'b1011);
    run_presses(4'b1011, 4, 0);
    expect_cycle("wait1", 0, 0, 1, 0, 0, 0);
    Unlock = 1'b1;
    expect_cycle("wait2", 0, 0, 1, 0, 0, 0);
    Unlock = 1'b0;
    expect_cycle("done_pass", 0, 0, 1, 1, 1, 0);
    expect_cycle("after_pass", 0, 0, 0, 0, 1, 0);

    // Early Unlock during the second press (Z): abort, later presses skipped
    do_start(4'b1011);
    run_presses(4'b1011, 1, 0);
    expect_cycle("p2c1", 0, 1, 1, 0, 0, 0);
    Unlock = 1'b1;
    expect_cycle("p2c2", 0, 1, 1, 0, 0, 0);
    Unlock = 1'b0;
    expect_cycle("early_done", 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 30; i++) expect_cycle("early_idle", 0, 0, 0, 0, 0, 1);

    // Start while busy at cycle 10 with code 0000: ignored
    do_start(4'b1011);
    run_presses(4'b1011, 4, 10);
    for (int i = 0; i < 16; i++) expect_cycle("wait_busy", 0, 0, 1, 0, 0, 0);
    expect_cycle("done_busy", 0, 0, 1, 1, 0, 1);
    // start during DONE is ignored as well
    start = 1'b0;
    expect_cycle("idle_busy", 0, 0, 0, 0, 0, 1);

    // Start pulsed in DONE must not launch a new sequence
    do_start(4'b1011);
    run_presses(4'b1011, 4, 0);
    for (int i = 0; i < 15; i++) expect_cycle("wait_d", 0, 0, 1, 0, 0, 0);
    start = 1'b1;
    code  = 4'b1111;
    expect_cycle("wait_d16", 0, 0, 1, 0, 0, 0);
    start = 1'b1;
    expect_cycle("done_d", 0, 0, 1, 1, 0, 1);
    start = 1'b0;
    expect_cycle("idle_d", 0, 0, 0, 0, 0, 1);

    // Reset during the third press, then a fresh full sequence
    do_start(4'b1011);
    run_presses(4'b1011, 2, 0);
    expect_cycle("p3c1", 1, 0, 1, 0, 0, 0);
    reset = 1'b0;
    tick();
    expect_cycle("mid_rst", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) expect_cycle("post_rst", 0, 0, 0, 0, 0, 0);
    do_start(4'b1011);
    run_presses(4'b1011, 4, 0);
    Unlock = 1'b1;
    expect_cycle("wait1_r", 0, 0, 1, 0, 0, 0);
    Unlock = 1'b0;
    expect_cycle("done_r", 0, 0, 1, 1, 1, 0);
    expect_cycle("idle_r", 0, 0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/numlock_code_player.md
Name: numlock_code_player

Overview:
- Sequential stimulus generator that drives the U/Z button interface of the number-lock state machine from the button side.
- Accepts a CODE_LEN-bit combination on a start request and plays it MSB first: a 1 bit is a U press, a 0 bit is a Z press. Each press is followed by a release gap.
- After the last release it monitors Unlock and reports pass/fail.
- Used as an on-board auto-dialer and as a reusable bench driver for the lock.

Parameters:
- CODE_LEN, 4, number of presses in a combination (1..16)
- PRESS_CYC, 5, clock cycles each press is held (>=1)
- GAP_CYC, 3, clock cycles both buttons are released after each press (>=1)
- WAIT_CYC, 16, maximum cycles to wait for Unlock after the final gap (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to play code; sampled only in IDLE
- code  in  CODE_LEN  combination, MSB played first; latched when start is accepted
- Unlock  in  1  unlock indication from the lock
- U  out  1  U button drive, registered
- Z  out  1  Z button drive, registered
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse in DONE
- pass  out  1  result: Unlock seen within the window; held until the next accepted start
- fail  out  1  result: timeout or early Unlock; held until the next accepted start

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE; U=Z=busy=done=pass=fail=0; counters and index =0; code register =0. Reset mid-operation aborts immediately, with outputs at reset values the next cycle.
- U and Z are never both 1. They are mutually exclusive by construction, and the bench asserts this.
- States: IDLE, PRESS, GAP, WAIT, DONE.
- IDLE:
  - If start=1 at edge k: latch code, idx=CODE_LEN-1, clear pass/fail, go to PRESS.
  - busy=1 and the first press are visible from cycle k+1.
- PRESS:
  - U=code_r[idx], Z=~code_r[idx], held exactly PRESS_CYC cycles.
  - Then go to GAP with U=Z=0.
- GAP:
  - U=Z=0 for exactly GAP_CYC cycles.
  - If idx>0: idx decrements and the FSM returns to PRESS.
  - If idx==0: go to WAIT.
- WAIT:
  - U=Z=0.
  - If Unlock=1 in any of the WAIT_CYC cycles: pass=1, go to DONE.
  - If WAIT_CYC cycles elapse without Unlock: fail=1, go to DONE.
- Early Unlock: if Unlock=1 in any PRESS or GAP cycle, fail=1, U=Z=0 next cycle, go to DONE. The remaining presses are skipped.
- DONE:
  - done=1 for one cycle, busy=1.
  - Then go to IDLE; busy=0 from the next cycle. pass/fail persist.
- Timing:
  - Total button activity: CODE_LEN*(PRESS_CYC+GAP_CYC) cycles.
  - Nominal accept-to-done latency on a pass with Unlock at WAIT cycle j (1-based): CODE_LEN*(PRESS_CYC+GAP_CYC)+j+1 cycles after edge k.
- start is ignored in every state other than IDLE, including DONE. A start concurrent with reset is ignored.
- code changes after acceptance have no effect.
- Counters are sized ceil(log2(max(PRESS_CYC,GAP_CYC,WAIT_CYC)+1)) bits. The index is ceil(log2(CODE_LEN)) bits, minimum 1. The counter reloads on every state entry, with no wrap-around carry between phases.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release, and keep start=0 for 20 cycles -> U=Z=busy=done=pass=fail=0 throughout.
- Play 4'b1011, defaults, with Unlock tied 0:
  - Expect U high 5 cycles, 3-cycle gap, Z high 5 cycles, gap, then U 5/gap, U 5/gap.
  - 16 WAIT cycles follow; fail=1 and a one-cycle done pulse 49 cycles after the start edge.
  - pass=0.
- Play 4'b1011 into a behavioural lock model that asserts Unlock 2 cycles after the final release -> pass=1, fail=0, done 35 cycles after the start edge.
- Early unlock: force Unlock=1 during the second press -> U=Z=0 the next cycle, fail=1, done pulse the following cycle, and the third and fourth presses never occur.
- Start while busy: pulse start again at cycle 10 with code=4'b0000 -> ignored, and the original 1011 sequence completes unchanged.
- Reset mid-sequence: drive reset=0 during the third press -> all outputs are 0 the next cycle and state is IDLE. A fresh start after release plays the full sequence from the MSB.
